layer_address_sequencer: RTL and testbench
==========================================

# layer_address_sequencer

Sequencing front end of the neural accelerator. It merges the control FSM, a two-word instruction store and the address generator into one block. After reset it runs one fully connected layer: for each neuron it streams neuron-read and weight-read addresses, flags the end of each neuron's dot product, and advances the neuron-write address. Its outputs drive the weight ROM, the neuron dual-port RAM and the MAC core.

## Interface
Parameters:
- `INIT_NK`, default 4: instruction word 0, the inputs per neuron (Nk).
- `INIT_NN`, default 2: instruction word 1, the neuron count (Nn).

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `read_neuro_base_addr`  in  8  base of the input activations.
- `read_weight_base_addr`  in  8  base of the weight block.
- `write_neuro_base_addr`  in  8  base of the output activations.
- `neuro_read_addr`  out  8  current activation read address.
- `weight_read_addr`  out  8  current weight read address.
- `neuro_write_addr`  out  8  current output neuron address.
- `read_en`  out  1  high while addresses are valid (RUN state).
- `alu_rst`  out  1  clears the MAC accumulator.
- `neuron_finished`  out  1  one-cycle pulse on the last input of each neuron.
- `finished`  out  1  layer complete; held until reset.

## Operation
- The FSM has four states: RST, INIT, RUN, DONE.
- **RST** (entered while `reset`=1):
  - all address outputs are 0; `read_en`, `neuron_finished` and `finished` are 0; `alu_rst` is 1.
  - Counters i (input index) and n (neuron index) are cleared.
- **INIT** (always the first cycle after `reset` drops):
  - `alu_rst`=1.
  - Base addresses are sampled into internal registers; they are not sampled anywhere else.
  - Nk and Nn are latched from the instruction store.
  - If Nk=0 or Nn=0, the next state is DONE. Otherwise it is RUN with i=0, n=0.
- **RUN**:
  - `read_en`=1, `alu_rst`=0.
  - `neuro_read_addr` = rbase + i.
  - `weight_read_addr` = wbase + n·Nk + i. This is kept as a running pointer that increments every RUN cycle; no multiplier is used.
  - `neuro_write_addr` = obase + n.
  - When i = Nk−1: `neuron_finished`=1 and i wraps to 0.
    - If n = Nn−1 the next state is DONE.
    - Otherwise n increments, so the write address advances on the following cycle.
- **DONE**:
  - `finished`=1 and `read_en`=0; all addresses hold their last values.
  - The block stays in DONE until `reset`.
- Arithmetic is modulo 256 on every address: the 8-bit sum wraps with no flag.
- `alu_rst` is asserted only in RST and INIT. Clearing the accumulator between neurons is done downstream using the delayed `neuron_finished`.
- A reset asserted in any state (including mid-RUN) forces RST values on the next edge. The sequence then restarts from INIT.

## Timing
- Let T0 be the first rising edge at which `reset` is sampled low. INIT occupies cycle T0→T1.
- The first valid address appears in the cycle after INIT. Nk·Nn RUN cycles follow back to back.
- `finished` rises in the cycle after the last RUN cycle, i.e. 1 + Nk·Nn cycles after the INIT cycle.
- `neuron_finished` is coincident with the last read address of its neuron (zero latency). Downstream logic applies any pipeline delay.
- All outputs are registered, so there are no combinational paths from the inputs.

## Configuration
- `INSTR_WRITE_EN` defined:
  - adds the ports `instr_we` (in, 1), `instr_addr` (in, 1) and `instr_wdata` (in, 8).
  - A write on a rising edge with `instr_we`=1 updates the addressed word, in any state, including during reset.
  - New values take effect at the next INIT only.
- Not defined:
  - those ports are absent, and the words are constants `INIT_NK`/`INIT_NN`.
- Reset never alters the instruction words.

## Test plan
- **Basic layer:** Nk=3, Nn=2, rbase=0x10, wbase=0x40, obase=0x80; release reset.
  - INIT: `alu_rst`=1.
  - Next 6 cycles: read 10,11,12,10,11,12; weight 40–45; write 80,80,80,81,81,81.
  - `neuron_finished` on cycles 3 and 6.
  - Then `finished`=1, addresses hold at 12/45/81.
- **Wrap:** wbase=0xFE, rbase=0xFF, Nk=2, Nn=2 → weight FE,FF,00,01; read FF,00,FF,00.
- **Degenerate:** Nk=0 (or Nn=0) → INIT followed directly by DONE; no `read_en`, no `neuron_finished`, `finished`=1.
- **Mid-run reset:** assert `reset` on RUN cycle 4 of the basic case → next cycle all addresses 0, `alu_rst`=1. Release → the full basic sequence is repeated exactly.
- **Base change:** change rbase during RUN → addresses unaffected until the next reset/INIT.
- **Instruction write** (`INSTR_WRITE_EN`): write word0=5 during DONE, then pulse reset → 5 reads per neuron, `neuron_finished` every 5th RUN cycle.

Source files
------------

// File: rtl/layer_address_sequencer.sv
// ---------------------------------------------------------------------------
// layer_address_sequencer
//
// Sequencing front end of the neural accelerator. It combines the control
// FSM, a two-word instruction store (word 0 = Nk inputs per neuron,
// word 1 = Nn neuron count) and the address generator. After reset it runs
// one fully connected layer, streaming activation and weight read addresses
// and stepping the output neuron address once per neuron.
//
// Optional feature macro: INSTR_WRITE_EN
//   defined   : instr_we / instr_addr / instr_wdata ports write the
//               instruction words (any state, reset included); new values
//               are used from the next INIT.
//   undefined : the words are the constants INIT_NK / INIT_NN.
//
// Ports
//   clk                   in   sole clock, rising edge
//   reset                 in   synchronous, active-high reset
//   read_neuro_base_addr  in   8  base of the input activations
//   read_weight_base_addr in   8  base of the weight block
//   write_neuro_base_addr in   8  base of the output activations
//   instr_we/addr/wdata   in   instruction write port (INSTR_WRITE_EN only)
//   neuro_read_addr       out  8  activation read address
//   weight_read_addr      out  8  weight read address
//   neuro_write_addr      out  8  output neuron address
//   read_en               out  1  addresses valid (RUN)
//   alu_rst               out  1  clears the MAC accumulator (RST/INIT)
//   neuron_finished       out  1  pulse on the last input of each neuron
//   finished              out  1  layer complete, held until reset
// ---------------------------------------------------------------------------
module layer_address_sequencer #(
   parameter int INIT_NK = 4,
   parameter int INIT_NN = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] read_neuro_base_addr,
   input  logic [7:0] read_weight_base_addr,
   input  logic [7:0] write_neuro_base_addr,
`ifdef INSTR_WRITE_EN
   input  logic       instr_we,
   input  logic       instr_addr,
   input  logic [7:0] instr_wdata,
`endif
   output logic [7:0] neuro_read_addr,
   output logic [7:0] weight_read_addr,
   output logic [7:0] neuro_write_addr,
   output logic       read_en,
   output logic       alu_rst,
   output logic       neuron_finished,
   output logic       finished
);

   localparam logic [1:0] ST_RST  = 2'd0;
   localparam logic [1:0] ST_INIT = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [7:0] instr_nk;
   logic [7:0] instr_nn;

`ifdef INSTR_WRITE_EN
   // Power-up contents come from the parameters; reset deliberately leaves
   // the words untouched so a program survives a layer restart.
   logic [7:0] instr_mem_reg [2] = '{8'(INIT_NK), 8'(INIT_NN)};

   always_ff @(posedge clk) begin
      if (instr_we) begin
         instr_mem_reg[instr_addr] <= instr_wdata;
      end
   end

   assign instr_nk = instr_mem_reg[0];
   assign instr_nn = instr_mem_reg[1];
`else
   assign instr_nk = 8'(INIT_NK);
   assign instr_nn = 8'(INIT_NN);
`endif

   logic [1:0] state_reg;
   logic [7:0] nk_reg;
   logic [7:0] nn_reg;
   logic [7:0] i_reg;
   logic [7:0] n_reg;
   logic [7:0] rbase_reg;
   logic [7:0] obase_reg;
   logic [7:0] neuro_read_addr_reg;
   logic [7:0] weight_read_addr_reg;
   logic [7:0] neuro_write_addr_reg;
   logic       read_en_reg;
   logic       alu_rst_reg;
   logic       neuron_finished_reg;
   logic       finished_reg;

   // Index of the input that follows i_reg within the current neuron.
   logic [7:0] i_next;
   logic       last_input;
   assign i_next     = i_reg + 8'd1;
   assign last_input = (i_reg == nk_reg - 8'd1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg            <= ST_RST;
         i_reg                <= 8'd0;
         n_reg                <= 8'd0;
         neuro_read_addr_reg  <= 8'd0;
         weight_read_addr_reg <= 8'd0;
         neuro_write_addr_reg <= 8'd0;
         read_en_reg          <= 1'b0;
         alu_rst_reg          <= 1'b1;
         neuron_finished_reg  <= 1'b0;
         finished_reg         <= 1'b0;
      end else begin
         case (state_reg)
            ST_RST: begin
               state_reg   <= ST_INIT;
               alu_rst_reg <= 1'b1;
            end

            ST_INIT: begin
               // Bases and instruction words are captured here only, so
               // later changes on the inputs do not disturb a running layer.
               nk_reg      <= instr_nk;
               nn_reg      <= instr_nn;
               rbase_reg   <= read_neuro_base_addr;
               obase_reg   <= write_neuro_base_addr;
               i_reg       <= 8'd0;
               n_reg       <= 8'd0;
               alu_rst_reg <= 1'b0;
               if (instr_nk == 8'd0 || instr_nn == 8'd0) begin
                  state_reg    <= ST_DONE;
                  finished_reg <= 1'b1;
               end else begin
                  // Load the first RUN address set straight from the inputs.
                  state_reg            <= ST_RUN;
                  read_en_reg          <= 1'b1;
                  neuro_read_addr_reg  <= read_neuro_base_addr;
                  weight_read_addr_reg <= read_weight_base_addr;
                  neuro_write_addr_reg <= write_neuro_base_addr;
                  neuron_finished_reg  <= (instr_nk == 8'd1);
               end
            end

            ST_RUN: begin
               if (last_input) begin
                  if (n_reg == nn_reg - 8'd1) begin
                     // Addresses hold their last values from here on.
                     state_reg           <= ST_DONE;
                     read_en_reg         <= 1'b0;
                     neuron_finished_reg <= 1'b0;
                     finished_reg        <= 1'b1;
                  end else begin
                     i_reg                <= 8'd0;
                     n_reg                <= n_reg + 8'd1;
                     neuro_read_addr_reg  <= rbase_reg;
                     weight_read_addr_reg <= weight_read_addr_reg + 8'd1;
                     neuro_write_addr_reg <= obase_reg + n_reg + 8'd1;
                     neuron_finished_reg  <= (nk_reg == 8'd1);
                  end
               end else begin
                  // Weight pointer walks the whole n*Nk+i block linearly.
                  i_reg                <= i_next;
                  neuro_read_addr_reg  <= rbase_reg + i_next;
                  weight_read_addr_reg <= weight_read_addr_reg + 8'd1;
                  neuron_finished_reg  <= (i_next == nk_reg - 8'd1);
               end
            end

            ST_DONE: begin
               state_reg <= ST_DONE;
            end

            default: begin
               state_reg   <= ST_RST;
               alu_rst_reg <= 1'b1;
            end
         endcase
      end
   end

   assign neuro_read_addr  = neuro_read_addr_reg;
   assign weight_read_addr = weight_read_addr_reg;
   assign neuro_write_addr = neuro_write_addr_reg;
   assign read_en          = read_en_reg;
   assign alu_rst          = alu_rst_reg;
   assign neuron_finished  = neuron_finished_reg;
   assign finished         = finished_reg;

endmodule

// File: tb/tb_layer_address_sequencer.sv
// ---------------------------------------------------------------------------
// tb_layer_address_sequencer
//
// Directed bench. Four sequencer instances share clock, reset and base
// inputs but carry different instruction constants:
//   dut0 Nk=3 Nn=2 (basic, mid-run reset, base change, instruction write)
//   dut1 Nk=2 Nn=2 (address wrap)
//   dut2 Nk=0 Nn=2 and dut3 Nk=3 Nn=0 (degenerate layers)
// ---------------------------------------------------------------------------
module tb_layer_address_sequencer;

   localparam int NDUT = 4;
   // Byte gi holds the constant of instance gi.
   localparam logic [31:0] NK_TAB = {8'd3, 8'd0, 8'd2, 8'd3};
   localparam logic [31:0] NN_TAB = {8'd0, 8'd2, 8'd2, 8'd2};

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] rbase = 8'd0;
   logic [7:0] wbase = 8'd0;
   logic [7:0] obase = 8'd0;
`ifdef INSTR_WRITE_EN
   logic       instr_we = 1'b0;
   logic       instr_addr = 1'b0;
   logic [7:0] instr_wdata = 8'd0;
`endif

   logic [7:0] nra [NDUT];
   logic [7:0] wra [NDUT];
   logic [7:0] nwa [NDUT];
   logic       ren [NDUT];
   logic       arst [NDUT];
   logic       nfin [NDUT];
   logic       fin [NDUT];

   int check_count = 0;
   int error_count = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      layer_address_sequencer #(
         .INIT_NK(int'(NK_TAB[gi*8 +: 8])),
         .INIT_NN(int'(NN_TAB[gi*8 +: 8]))
      ) u_dut (
         .clk                  (clk),
         .reset                (reset),
         .read_neuro_base_addr (rbase),
         .read_weight_base_addr(wbase),
         .write_neuro_base_addr(obase),
`ifdef INSTR_WRITE_EN
         .instr_we             (instr_we),
         .instr_addr           (instr_addr),
         .instr_wdata          (instr_wdata),
`endif
         .neuro_read_addr      (nra[gi]),
         .weight_read_addr     (wra[gi]),
         .neuro_write_addr     (nwa[gi]),
         .read_en              (ren[gi]),
         .alu_rst              (arst[gi]),
         .neuron_finished      (nfin[gi]),
         .finished             (fin[gi])
      );
   end

   task automatic check_value(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      check_count++;
      if (obs !== exp) begin
         error_count++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_rst(input int d, input string tag);
      check_value({tag, " rst read"},    32'(nra[d]),  32'h0);
      check_value({tag, " rst weight"},  32'(wra[d]),  32'h0);
      check_value({tag, " rst write"},   32'(nwa[d]),  32'h0);
      check_value({tag, " rst read_en"}, 32'(ren[d]),  32'h0);
      check_value({tag, " rst alu_rst"}, 32'(arst[d]), 32'h1);
      check_value({tag, " rst nf"},      32'(nfin[d]), 32'h0);
      check_value({tag, " rst fin"},     32'(fin[d]),  32'h0);
   endtask

   // Resets, runs one layer on instance d and checks every cycle against the
   // address formulas. stop_at >= 0 asserts reset after that RUN cycle and
   // returns; change_at >= 0 changes the bases after that RUN cycle.
   task automatic run_layer(input int d, input int nk, input int nn,
                            input logic [7:0] rb, input logic [7:0] wb,
                            input logic [7:0] ob, input int stop_at,
                            input int change_at);
      int total;
      logic [7:0] er, ew, eo;
      string tag;
      total = nk * nn;
      rbase = rb;
      wbase = wb;
      obase = ob;
      reset = 1'b1;
      tick();
      tag = $sformatf("d%0d", d);
      check_rst(d, tag);
      reset = 1'b0;
      tick();
      $display("dut%0d INIT: alu_rst=%0b read_en=%0b", d, arst[d], ren[d]);
      check_value({tag, " init alu_rst"}, 32'(arst[d]), 32'h1);
      check_value({tag, " init read_en"}, 32'(ren[d]),  32'h0);
      check_value({tag, " init fin"},     32'(fin[d]),  32'h0);
      for (int k = 0; k < total; k++) begin
         tick();
         er = rb + 8'(k % nk);
         ew = wb + 8'(k);
         eo = ob + 8'(k / nk);
         tag = $sformatf("d%0d k%0d", d, k);
         $display("dut%0d run %0d: read=%02h weight=%02h write=%02h nf=%0b",
                  d, k, nra[d], wra[d], nwa[d], nfin[d]);
         check_value({tag, " read"},    32'(nra[d]),  32'(er));
         check_value({tag, " weight"},  32'(wra[d]),  32'(ew));
         check_value({tag, " write"},   32'(nwa[d]),  32'(eo));
         check_value({tag, " nf"},      32'(nfin[d]), 32'((k % nk) == nk - 1));
         check_value({tag, " read_en"}, 32'(ren[d]),  32'h1);
         check_value({tag, " alu_rst"}, 32'(arst[d]), 32'h0);
         check_value({tag, " fin"},     32'(fin[d]),  32'h0);
         if (k == change_at) begin
            rbase = 8'h30;
            wbase = 8'h70;
            obase = 8'h90;
         end
         if (k == stop_at) begin
            reset = 1'b1;
            return;
         end
      end
      if (total > 0) begin
         er = rb + 8'(nk - 1);
         ew = wb + 8'(total - 1);
         eo = ob + 8'(nn - 1);
      end else begin
         er = 8'h0;
         ew = 8'h0;
         eo = 8'h0;
      end
      for (int h = 0; h < 2; h++) begin
         tick();
         tag = $sformatf("d%0d done%0d", d, h);
         $display("dut%0d DONE: fin=%0b read=%02h weight=%02h write=%02h",
                  d, fin[d], nra[d], wra[d], nwa[d]);
         check_value({tag, " fin"},     32'(fin[d]),  32'h1);
         check_value({tag, " read_en"}, 32'(ren[d]),  32'h0);
         check_value({tag, " nf"},      32'(nfin[d]), 32'h0);
         check_value({tag, " alu_rst"}, 32'(arst[d]), 32'h0);
         check_value({tag, " read"},    32'(nra[d]),  32'(er));
         check_value({tag, " weight"},  32'(wra[d]),  32'(ew));
         check_value({tag, " write"},   32'(nwa[d]),  32'(eo));
      end
   endtask

   // Hand-computed basic layer (Nk=3, Nn=2, bases 10/40/80).
   logic [7:0] basic_read  [6] = '{8'h10, 8'h11, 8'h12, 8'h10, 8'h11, 8'h12};
   logic [7:0] basic_write [6] = '{8'h80, 8'h80, 8'h80, 8'h81, 8'h81, 8'h81};
   logic       basic_nf    [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

   initial begin
      repeat (2) tick();

      // Basic layer against the literal table first.
      rbase = 8'h10; wbase = 8'h40; obase = 8'h80;
      reset = 1'b1;
      tick();
      check_rst(0, "basic");
      reset = 1'b0;
      tick();
      check_value("basic init alu_rst", 32'(arst[0]), 32'h1);
      for (int k = 0; k < 6; k++) begin
         tick();
         $display("basic run %0d: read=%02h weight=%02h write=%02h nf=%0b",
                  k, nra[0], wra[0], nwa[0], nfin[0]);
         check_value($sformatf("basic k%0d read", k),   32'(nra[0]),  32'(basic_read[k]));
         check_value($sformatf("basic k%0d weight", k), 32'(wra[0]),  32'h40 + 32'(k));
         check_value($sformatf("basic k%0d write", k),  32'(nwa[0]),  32'(basic_write[k]));
         check_value($sformatf("basic k%0d nf", k),     32'(nfin[0]), 32'(basic_nf[k]));
      end
      tick();
      $display("basic DONE: fin=%0b read=%02h weight=%02h write=%02h",
               fin[0], nra[0], wra[0], nwa[0]);
      check_value("basic fin",    32'(fin[0]), 32'h1);
      check_value("basic hold r", 32'(nra[0]), 32'h12);
      check_value("basic hold w", 32'(wra[0]), 32'h45);
      check_value("basic hold o", 32'(nwa[0]), 32'h81);

      // Address wrap: weight FE,FF,00,01; read FF,00,FF,00.
      run_layer(1, 2, 2, 8'hFF, 8'hFE, 8'h80, -1, -1);

      // Degenerate layers go INIT -> DONE.
      run_layer(2, 0, 2, 8'h10, 8'h40, 8'h80, -1, -1);
      run_layer(3, 3, 0, 8'h10, 8'h40, 8'h80, -1, -1);

      // Mid-run reset on RUN cycle 4, then the full layer again.
      run_layer(0, 3, 2, 8'h10, 8'h40, 8'h80, 3, -1);
      tick();
      $display("midrun reset: read=%02h weight=%02h write=%02h alu_rst=%0b",
               nra[0], wra[0], nwa[0], arst[0]);
      check_rst(0, "midrun");
      run_layer(0, 3, 2, 8'h10, 8'h40, 8'h80, -1, -1);

      // Base change during RUN does not disturb the layer; the next INIT
      // picks up the new bases.
      run_layer(0, 3, 2, 8'h10, 8'h40, 8'h80, -1, 1);
      run_layer(0, 3, 2, 8'h30, 8'h70, 8'h90, -1, -1);

`ifdef INSTR_WRITE_EN
      // dut0 is in DONE: write Nk=5, then restart the layer.
      instr_we = 1'b1;
      instr_addr = 1'b0;
      instr_wdata = 8'd5;
      tick();
      instr_we = 1'b0;
      $display("instr write: word0=5");
      run_layer(0, 5, 2, 8'h10, 8'h40, 8'h80, -1, -1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule
